// File: rtl/hex_scan.sv
// hex_scan: multiplexed hex display scanner with tear-free frame-synchronous update
module hex_scan #(
   parameter int DIGITS        = 4,
   parameter int DIV           = 50000,
   parameter int ACTIVE_LOW    = 1,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);
   localparam int IW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int CW  = $clog2(DIV);
   localparam bit INV = ACTIVE_LOW != 0;
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] disp_val, pend_val;
   logic [DIGITS-1:0]   disp_dp, pend_dp;
   logic                pend_valid, wrap_q, tick, wrap, blank, dp_hi;
   logic [3:0]          nib;
   logic [6:0]          seg_hi;
   logic [DIGITS-1:0]   an_hi;
   // tick/wrap decode and active-high view of the currently indexed digit
   always_comb begin
      tick   = cnt == CW'(DIV - 1);
      wrap   = tick && idx == IW'(DIGITS - 1);
      nib    = disp_val[{idx, 2'b00} +: 4];
      blank  = BLANK_LEADING != 0 && idx != '0 && (disp_val >> {idx, 2'b00}) == '0;
      seg_hi = blank ? 7'h00 : SEG_LUT[nib];
      dp_hi  = !blank && disp_dp[idx];
      an_hi  = DIGITS'(1) << idx;
   end
   // divider and digit index; wrap_q remembers the wrap so frame lines up with digit 0 output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         idx    <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt    <= tick ? '0 : cnt + 1'b1;
         idx    <= tick ? (wrap ? '0 : idx + 1'b1) : idx;
         wrap_q <= wrap;
      end
   end
   // pending/display registers: display only changes on a wrap so a frame never tears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_val   <= '0;
         disp_dp    <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else if (load && wrap) begin
         disp_val   <= value;
         disp_dp    <= dp_in;
         pend_valid <= 1'b0;
      end else if (wrap && pend_valid) begin
         disp_val   <= pend_val;
         disp_dp    <= pend_dp;
         pend_valid <= 1'b0;
      end else if (load) begin
         pend_val   <= value;
         pend_dp    <= dp_in;
         pend_valid <= 1'b1;
      end
   end
   // registered drivers with polarity applied; frame stays active-high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg   <= {7{INV}};
         dp    <= INV;
         an    <= {DIGITS{INV}};
         frame <= 1'b0;
      end else begin
         seg   <= seg_hi ^ {7{INV}};
         dp    <= dp_hi ^ INV;
         an    <= an_hi ^ {DIGITS{INV}};
         frame <= wrap_q;
      end
   end
endmodule

// File: tb/tb_hex_scan.sv
// tb_hex_scan: directed checks of scanning, loading, blanking and reset behaviour
module tb_hex_scan;
   logic        clk, rst, load, load2;
   logic [15:0] value;
   logic [7:0]  value2;
   logic [3:0]  dp_in, an;
   logic [1:0]  dp_in2, an2;
   logic [6:0]  seg, seg2;
   logic        dp, frame, dp2, frame2;
   int checks = 0;
   int errors = 0;

   hex_scan #(.DIGITS(4), .DIV(4), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
      .seg(seg), .dp(dp), .an(an), .frame(frame));

   hex_scan #(.DIGITS(2), .DIV(4), .ACTIVE_LOW(0), .BLANK_LEADING(0)) dut2 (
      .clk(clk), .rst(rst), .load(load2), .value(value2), .dp_in(dp_in2),
      .seg(seg2), .dp(dp2), .an(an2), .frame(frame2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_frame(input bit second);
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = second ? frame2 : frame;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL frame_timeout dut%0d got no frame pulse, expected one within 40 cycles", second ? 2 : 1);
      end
   endtask

   task automatic test_reset;
      rst = 1; load = 0; load2 = 0; value = 0; value2 = 0; dp_in = 0; dp_in2 = 0;
      repeat (2) @(negedge clk);
      checks++; if (an !== 4'hF) begin errors++; $display("FAIL rst_an got %h expected f", an); end
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got %h expected 7f", seg); end
      checks++; if (dp !== 1'b1 || frame !== 1'b0) begin errors++; $display("FAIL rst_dp_frame got %b%b expected 10", dp, frame); end
      checks++; if (an2 !== 2'b00 || seg2 !== 7'h00) begin errors++; $display("FAIL rst_dut2 got an=%b seg=%h expected 00/00", an2, seg2); end
      rst = 0;
      @(negedge clk);
      checks++; if (an !== 4'b1110 || seg !== 7'h40) begin errors++; $display("FAIL first_clk got an=%b seg=%h expected 1110/40", an, seg); end
      checks++; if (frame !== 1'b0) begin errors++; $display("FAIL first_clk_frame got %b expected 0", frame); end
      checks++; if (an2 !== 2'b01 || seg2 !== 7'h3F) begin errors++; $display("FAIL first_clk_dut2 got an=%b seg=%h expected 01/3f", an2, seg2); end
   endtask

   task automatic test_scan;
      repeat (4) @(negedge clk);
      checks++; if (an !== 4'b1101 || seg !== 7'h7F) begin errors++; $display("FAIL scan_d1 got an=%b seg=%h expected 1101/7f", an, seg); end
      repeat (4) @(negedge clk);
      checks++; if (an !== 4'b1011 || seg !== 7'h7F) begin errors++; $display("FAIL scan_d2 got an=%b seg=%h expected 1011/7f", an, seg); end
      repeat (4) @(negedge clk);
      checks++; if (an !== 4'b0111 || seg !== 7'h7F || frame !== 1'b0) begin errors++; $display("FAIL scan_d3 got an=%b seg=%h fr=%b expected 0111/7f/0", an, seg, frame); end
      repeat (4) @(negedge clk);
      checks++; if (an !== 4'b1110 || seg !== 7'h40 || frame !== 1'b1) begin errors++; $display("FAIL scan_wrap got an=%b seg=%h fr=%b expected 1110/40/1", an, seg, frame); end
      @(negedge clk);
      checks++; if (frame !== 1'b0) begin errors++; $display("FAIL frame_width got %b expected 0", frame); end
   endtask

   task automatic test_load_midframe;
      load = 1; value = 16'h00A5; dp_in = 4'b0000;
      @(negedge clk);
      load = 0;
      checks++; if (seg !== 7'h40 || an !== 4'b1110) begin errors++; $display("FAIL midframe_hold got an=%b seg=%h expected 1110/40", an, seg); end
      wait_frame(0);
      checks++; if (an !== 4'b1110 || seg !== 7'h12 || dp !== 1'b1) begin errors++; $display("FAIL a5_d0 got an=%b seg=%h dp=%b expected 1110/12/1", an, seg, dp); end
      repeat (4) @(negedge clk);
      checks++; if (an !== 4'b1101 || seg !== 7'h08) begin errors++; $display("FAIL a5_d1 got an=%b seg=%h expected 1101/08", an, seg); end
      repeat (4) @(negedge clk);
      checks++; if (seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL a5_d2 got seg=%h dp=%b expected 7f/1", seg, dp); end
      repeat (4) @(negedge clk);
      checks++; if (an !== 4'b0111 || seg !== 7'h7F) begin errors++; $display("FAIL a5_d3 got an=%b seg=%h expected 0111/7f", an, seg); end
   endtask

   task automatic test_back_to_back;
      wait_frame(0);
      load = 1; value = 16'h1234;
      @(negedge clk);
      value = 16'hBEEF;
      @(negedge clk);
      load = 0;
      checks++; if (seg !== 7'h12) begin errors++; $display("FAIL b2b_hold got seg=%h expected 12", seg); end
      wait_frame(0);
      checks++; if (seg !== 7'h0E) begin errors++; $display("FAIL beef_d0 got seg=%h expected 0e", seg); end
      repeat (4) @(negedge clk);
      checks++; if (seg !== 7'h06) begin errors++; $display("FAIL beef_d1 got seg=%h expected 06", seg); end
      repeat (4) @(negedge clk);
      checks++; if (seg !== 7'h06) begin errors++; $display("FAIL beef_d2 got seg=%h expected 06", seg); end
      repeat (4) @(negedge clk);
      checks++; if (an !== 4'b0111 || seg !== 7'h03) begin errors++; $display("FAIL beef_d3 got an=%b seg=%h expected 0111/03", an, seg); end
   endtask

   task automatic test_boundary_load;
      wait_frame(0);
      repeat (14) @(negedge clk);
      load = 1; value = 16'h8000; dp_in = 4'b0001;
      @(negedge clk);
      load = 0; dp_in = 4'b0000;
      checks++; if (an !== 4'b0111 || seg !== 7'h03) begin errors++; $display("FAIL bnd_pre got an=%b seg=%h expected 0111/03", an, seg); end
      @(negedge clk);
      checks++; if (frame !== 1'b1 || an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b0) begin errors++; $display("FAIL bnd_d0 got fr=%b an=%b seg=%h dp=%b expected 1/1110/40/0", frame, an, seg, dp); end
      repeat (4) @(negedge clk);
      checks++; if (seg !== 7'h40 || dp !== 1'b1) begin errors++; $display("FAIL bnd_d1 got seg=%h dp=%b expected 40/1", seg, dp); end
      repeat (4) @(negedge clk);
      checks++; if (seg !== 7'h40) begin errors++; $display("FAIL bnd_d2 got seg=%h expected 40", seg); end
      repeat (4) @(negedge clk);
      checks++; if (an !== 4'b0111 || seg !== 7'h00) begin errors++; $display("FAIL bnd_d3 got an=%b seg=%h expected 0111/00", an, seg); end
      wait_frame(0);
      checks++; if (seg !== 7'h40 || dp !== 1'b0) begin errors++; $display("FAIL bnd_next got seg=%h dp=%b expected 40/0", seg, dp); end
   endtask

   task automatic test_reset_pending;
      wait_frame(0);
      repeat (2) @(negedge clk);
      load = 1; value = 16'h7777; dp_in = 4'b1111;
      @(negedge clk);
      load = 0; dp_in = 4'b0000;
      @(negedge clk);
      #2 rst = 1;
      #1;
      checks++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame !== 1'b0) begin errors++; $display("FAIL async_rst got an=%b seg=%h dp=%b fr=%b expected 1111/7f/1/0", an, seg, dp, frame); end
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      checks++; if (an !== 4'b1110 || seg !== 7'h40) begin errors++; $display("FAIL rst_release got an=%b seg=%h expected 1110/40", an, seg); end
      wait_frame(0);
      checks++; if (seg !== 7'h40 || dp !== 1'b1) begin errors++; $display("FAIL rst_discard_d0 got seg=%h dp=%b expected 40/1", seg, dp); end
      repeat (4) @(negedge clk);
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_discard_d1 got seg=%h expected 7f", seg); end
   endtask

   task automatic test_two_digit;
      load2 = 1; value2 = 8'h0F; dp_in2 = 2'b00;
      @(negedge clk);
      load2 = 0;
      wait_frame(1);
      checks++; if (an2 !== 2'b01 || seg2 !== 7'h71 || dp2 !== 1'b0) begin errors++; $display("FAIL two_d0 got an=%b seg=%h dp=%b expected 01/71/0", an2, seg2, dp2); end
      repeat (4) @(negedge clk);
      checks++; if (an2 !== 2'b10 || seg2 !== 7'h3F) begin errors++; $display("FAIL two_d1 got an=%b seg=%h expected 10/3f", an2, seg2); end
      repeat (4) @(negedge clk);
      checks++; if (an2 !== 2'b01 || frame2 !== 1'b1) begin errors++; $display("FAIL two_wrap got an=%b fr=%b expected 01/1", an2, frame2); end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_load_midframe;
      test_back_to_back;
      test_boundary_load;
      test_reset_pending;
      test_two_digit;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
